// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared types and defaults for the two-port RAM arbiter.
//   state_t  - arbiter FSM states
//   req_id_t - requester identifier (0 or 1)
package ram_arbiter_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ADDR_BITS  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_DONE
  } state_t;

  typedef logic req_id_t;

  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin selector (purely combinational).
//   i_req   - request vector, bit N from requester N
//   i_last  - requester granted most recently
//   o_grant - selected requester id
//   o_valid - at least one request present
module rr_arbiter2
  import ram_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  req_id_t    i_last,
  output req_id_t    o_grant,
  output logic       o_valid
);

  always_comb begin
    o_valid = |i_req;
    o_grant = REQ0;
    if (i_req == 2'b11) begin
      // Tie: the requester not served last time wins.
      o_grant = (i_last == REQ0) ? REQ1 : REQ0;
    end else if (i_req[1]) begin
      o_grant = REQ1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: arbitrates two requesters onto one synchronous single-port RAM.
//   clk, rst                      - clock, synchronous active-high reset
//   reqN/weN/addrN/wdataN         - request, direction, address, write data (N=0,1)
//   ackN                          - one-cycle completion pulse
//   rdataN                        - last read result for requester N
//   busy                          - high whenever the FSM is not idle
//   ram_cs/ram_wr_en/ram_out_en   - RAM controls, decoded from state only
//   ram_addr/ram_wdata/ram_rdata  - RAM address, write data, read data
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_BITS  = DEF_ADDR_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_BITS-1:0]  addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_BITS-1:0]  addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  busy,
  output logic                  ram_cs,
  output logic                  ram_wr_en,
  output logic                  ram_out_en,
  output logic [ADDR_BITS-1:0]  ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  state_t                r_state;
  state_t                w_state_nxt;
  req_id_t               r_id;
  req_id_t               r_last;
  logic [ADDR_BITS-1:0]  r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata0;
  logic [DATA_WIDTH-1:0] r_rdata1;
  req_id_t               w_grant;
  logic                  w_valid;
  logic                  w_sel_we;

  rr_arbiter2 u_rr (
    .i_req   ({req1, req0}),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_valid (w_valid)
  );

  assign w_sel_we = (w_grant == REQ1) ? we1 : we0;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state plus state-decoded outputs; no path from reqN to the RAM pins.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b1;
    ram_cs      = 1'b0;
    ram_wr_en   = 1'b0;
    ram_out_en  = 1'b0;
    ack0        = 1'b0;
    ack1        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (w_valid) w_state_nxt = w_sel_we ? ST_WR : ST_RD_ADDR;
      end
      ST_WR: begin
        ram_cs      = 1'b1;
        ram_wr_en   = 1'b1;
        w_state_nxt = ST_DONE;
      end
      ST_RD_ADDR: begin
        ram_cs      = 1'b1;
        w_state_nxt = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        ram_cs      = 1'b1;
        ram_out_en  = 1'b1;
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        ack0        = (r_id == REQ0);
        ack1        = (r_id == REQ1);
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The direction is carried by the state itself, so only id/addr/wdata are latched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id     <= REQ0;
      r_last   <= REQ1;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      if (r_state == ST_IDLE && w_valid) begin
        r_id    <= w_grant;
        r_addr  <= (w_grant == REQ1) ? addr1 : addr0;
        r_wdata <= (w_grant == REQ1) ? wdata1 : wdata0;
      end
      if (w_state_nxt == ST_DONE) r_last <= r_id;
      if (r_state == ST_RD_DATA) begin
        if (r_id == REQ0) r_rdata0 <= ram_rdata;
        else              r_rdata1 <= ram_rdata;
      end
    end
  end

  assign ram_addr  = r_addr;
  assign ram_wdata = r_wdata;
  assign rdata0    = r_rdata0;
  assign rdata1    = r_rdata1;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and randomized checks of ram_arbiter against a
// transaction-level model (memory array, last-grant, per-requester read data).
module tb_ram_arbiter;

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [7:0] data;
  } txn_t;

  // Expected {busy, cs, wr_en, out_en, ack0, ack1} for each cycle kind.
  localparam logic [5:0] PH_IDLE = 6'b000000;
  localparam logic [5:0] PH_WR   = 6'b111000;
  localparam logic [5:0] PH_RA   = 6'b110000;
  localparam logic [5:0] PH_RD   = 6'b110100;
  localparam logic [5:0] PH_ACK0 = 6'b100010;
  localparam logic [5:0] PH_ACK1 = 6'b100001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [3:0] addr0 = '0, addr1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic       ack0, ack1, busy, ram_cs, ram_wr_en, ram_out_en;
  logic [7:0] rdata0, rdata1, ram_wdata, ram_rdata;
  logic [3:0] ram_addr;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_ack [2];
  bit started = 1'b0;

  // Reference model state.
  logic [7:0] ref_mem [16];
  logic [7:0] exp_rd [2];
  int         ref_last;

  // External synchronous RAM: registered read, output valid only under out_en.
  logic [7:0] mem [16];
  logic [7:0] ram_q;
  always @(posedge clk) begin
    if (ram_cs && ram_wr_en) mem[ram_addr] <= ram_wdata;
    if (ram_cs && !ram_wr_en) ram_q <= mem[ram_addr];
  end
  assign ram_rdata = (ram_cs && !ram_wr_en && ram_out_en) ? ram_q : 8'hEE;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  ram_arbiter #(.DATA_WIDTH(8), .ADDR_BITS(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .busy(busy), .ram_cs(ram_cs), .ram_wr_en(ram_wr_en), .ram_out_en(ram_out_en),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] ctl_vec();
    return {busy, ram_cs, ram_wr_en, ram_out_en, ack0, ack1};
  endfunction

  // Scoreboard: RAM idle in IDLE/DONE, acks mutually exclusive.
  always @(negedge clk) begin
    if (started && !rst) begin
      if (!busy) check("sb_cs_idle", {31'd0, ram_cs}, 32'd0);
      if (ack0 || ack1) check("sb_cs_done", {29'd0, ram_cs, ram_wr_en, ram_out_en}, 32'd0);
      check("sb_ack_excl", {31'd0, ack0 & ack1}, 32'd0);
    end
  end

  // Assert reset for one edge and check every reset value.
  task automatic do_reset(input string tag);
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    check({tag, "_ctl"}, {26'd0, ctl_vec()}, 32'd0);
    check({tag, "_rdata0"}, {24'd0, rdata0}, 32'd0);
    check({tag, "_rdata1"}, {24'd0, rdata1}, 32'd0);
    check({tag, "_addr"}, {28'd0, ram_addr}, 32'd0);
    check({tag, "_wdata"}, {24'd0, ram_wdata}, 32'd0);
    rst = 1'b0;
    exp_rd[0] = '0; exp_rd[1] = '0; ref_last = 1;
  endtask

  // Entered and left at a negedge with the FSM idle. Drives the requests for
  // the set mask, predicts service order and per-cycle outputs from the model.
  task automatic run_txns(input logic [1:0] mask, input txn_t a, input txn_t b);
    txn_t        t [2];
    int unsigned order [$];
    logic [5:0]  ph [$];
    int unsigned w;
    t[0] = a; t[1] = b;
    req0 = mask[0]; we0 = a.we; addr0 = a.addr; wdata0 = a.data;
    req1 = mask[1]; we1 = b.we; addr1 = b.addr; wdata1 = b.data;
    if (mask == 2'b11) begin
      order.push_back(ref_last == 1 ? 0 : 1);
      order.push_back(ref_last == 1 ? 1 : 0);
    end else begin
      order.push_back(mask[1] ? 1 : 0);
    end
    foreach (order[k]) begin
      w = order[k];
      ph.delete();
      if (k > 0) ph.push_back(PH_IDLE);
      if (t[w].we) ph.push_back(PH_WR);
      else begin ph.push_back(PH_RA); ph.push_back(PH_RD); end
      ph.push_back(w == 0 ? PH_ACK0 : PH_ACK1);
      foreach (ph[i]) begin
        @(negedge clk);
        check($sformatf("ctl_r%0d_c%0d", w, i), {26'd0, ctl_vec()}, {26'd0, ph[i]});
        if (ph[i] != PH_IDLE) begin
          check("ram_addr", {28'd0, ram_addr}, {28'd0, t[w].addr});
          check("ram_wdata", {24'd0, ram_wdata}, {24'd0, t[w].data});
        end
        if (i == ph.size() - 1) begin
          if (w == 0) req0 = 1'b0; else req1 = 1'b0;
          if (t[w].we) ref_mem[t[w].addr] = t[w].data;
          else exp_rd[w] = ref_mem[t[w].addr];
          ref_last = int'(w);
          last_ack[w] = cyc;
          check("rdata0", {24'd0, rdata0}, {24'd0, exp_rd[0]});
          check("rdata1", {24'd0, rdata1}, {24'd0, exp_rd[1]});
        end
      end
    end
    @(negedge clk);
    check("post_idle", {26'd0, ctl_vec()}, {26'd0, PH_IDLE});
  endtask

  function automatic txn_t mk(input logic we, input logic [3:0] ad, input logic [7:0] d);
    txn_t r;
    r.we = we; r.addr = ad; r.data = d;
    return r;
  endfunction

  function automatic txn_t rnd_txn();
    return mk(1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom));
  endfunction

  initial begin
    int   t_prev;
    txn_t nul;
    nul = mk(1'b0, 4'd0, 8'd0);
    @(negedge clk);
    do_reset("reset");
    started = 1'b1;

    // Write then read of addr 3 from different requesters.
    run_txns(2'b01, mk(1'b1, 4'd3, 8'hA5), nul);
    run_txns(2'b10, nul, mk(1'b0, 4'd3, 8'h00));
    check("rd_a5", {24'd0, rdata1}, 32'h0000_00A5);

    // Ties after reset: 0 then 1, and subsequent ties alternate.
    do_reset("reset2");
    run_txns(2'b11, mk(1'b1, 4'd1, 8'h11), mk(1'b1, 4'd2, 8'h22));
    run_txns(2'b11, mk(1'b0, 4'd2, 8'h00), mk(1'b0, 4'd1, 8'h00));
    run_txns(2'b11, mk(1'b0, 4'd1, 8'h00), mk(1'b1, 4'd2, 8'h33));

    // Reset during RD_DATA: no ack, FSM idle, later read works.
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'd3;
    @(negedge clk);
    check("abort_ra", {26'd0, ctl_vec()}, {26'd0, PH_RA});
    @(negedge clk);
    check("abort_rd", {26'd0, ctl_vec()}, {26'd0, PH_RD});
    do_reset("abort");
    @(negedge clk);
    check("abort_noack", {26'd0, ctl_vec()}, {26'd0, PH_IDLE});
    run_txns(2'b01, mk(1'b0, 4'd3, 8'h00), nul);

    // Reset during WR: the write still lands in the RAM.
    req1 = 1'b1; we1 = 1'b1; addr1 = 4'd7; wdata1 = 8'h5C;
    @(negedge clk);
    check("wrrst_wr", {26'd0, ctl_vec()}, {26'd0, PH_WR});
    ref_mem[7] = 8'h5C;
    do_reset("wrrst");
    run_txns(2'b01, mk(1'b0, 4'd7, 8'h00), nul);

    // Back-to-back writes at address extremes, 3-cycle ack spacing.
    run_txns(2'b01, mk(1'b1, 4'd15, 8'hF0), nul);
    t_prev = last_ack[0];
    run_txns(2'b01, mk(1'b1, 4'd0, 8'h0F), nul);
    check("ack_spacing", 32'(last_ack[0] - t_prev), 32'd3);
    run_txns(2'b11, mk(1'b0, 4'd15, 8'h00), mk(1'b0, 4'd0, 8'h00));

    // Randomized: fill memory, then mixed traffic.
    for (int unsigned i = 0; i < 16; i++)
      run_txns(2'(i[0] ? 2'b10 : 2'b01), mk(1'b1, 4'(i), 8'($urandom)),
               mk(1'b1, 4'(i), 8'($urandom)));
    for (int unsigned i = 0; i < 60; i++)
      run_txns(2'($urandom_range(1, 3)), rnd_txn(), rnd_txn());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
